load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the core data bus: accepts load/store requests from the execute stage and drives the rd/wd, size, address and data signals of the data bus responder.
- Checks RV32I alignment and address range before issuing. Only legal accesses reach the bus.
- Waits for the responder's ready/!busy handshake, captures load data, and sign- or zero-extends it per funct3.
- Returns a one-cycle response pulse with data or an exception flag to the pipeline.

Parameters:
- RAM_START, 32'h0000_0000, first legal data address (inclusive)
- RAM_END, 32'h0000_0FFF, last legal data address (inclusive)
- TIMEOUT, 15, maximum cycles spent in ISSUE waiting for ready && !busy before a timeout exception
- CNT_W, 4, width of the wait counter; must satisfy 2**CNT_W > TIMEOUT

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-low
- req_valid  in  1  pipeline presents a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; any other value is illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_ready  out  1  unit can accept a request (IDLE only)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and exceptions
- exc_misaligned  out  1  valid with resp_valid
- exc_access  out  1  address out of range or illegal funct3; valid with resp_valid
- exc_timeout  out  1  valid with resp_valid
- bus_rd  out  1  read strobe to the responder
- bus_wd  out  1  write strobe to the responder
- bus_size_in  out  2  write size: 00 byte, 01 half, 10 word
- bus_size_out  out  2  read size, same encoding
- bus_addr_in  out  32  write address
- bus_addr_out  out  32  read address
- bus_data_in  out  32  write data to the responder
- bus_data_out  in  32  read data from the responder, right-aligned, combinationally valid while bus_rd is high
- bus_ready  in  1  responder ready
- bus_busy  in  1  responder busy

Behaviour:
- Reset (rst==0 at a posedge):
  - State goes to IDLE and the wait counter clears.
  - All registered outputs clear to 0: resp_valid, resp_rdata, all exc_*, bus address, size and data.
  - bus_rd and bus_wd are decoded from state, so they are 0 from the first cycle after the reset edge.
  - Reset mid-access abandons the access with no response pulse.
- States: IDLE, ISSUE, RESP.
- req_ready = (state==IDLE).
- IDLE, when req_valid is high:
  - Latch we, funct3 and addr.
  - Size = funct3[1:0].
  - bus_data_in = req_wdata masked to the size (byte: {24'b0, wdata[7:0]}; half: {16'b0, wdata[15:0]}).
  - Drive bus_addr_in = bus_addr_out = latched addr and bus_size_in = bus_size_out = size, so the responder's alignment check on both ports stays clean.
- Pre-checks at accept, in priority order:
  1. Illegal funct3 (011, 110, 111, or a store with funct3[2]==1): set exc_access.
  2. Misaligned (half with addr[0]!=0, word with addr[1:0]!=0): set exc_misaligned.
  3. Address outside RAM_START..RAM_END: set exc_access.
  - Any failed check goes directly to RESP. No strobe is ever asserted.
- Otherwise go to ISSUE with the wait counter at 0.
- ISSUE:
  - Strobe condition: bus_rd = !we && bus_ready && !bus_busy; bus_wd = we && bus_ready && !bus_busy.
  - On the edge where a strobe is high:
    - Load: capture bus_data_out and extend it. LB sign-extends [7:0], LBU zero-extends [7:0], LH sign-extends [15:0], LHU zero-extends [15:0], LW passes 32 bits.
    - Store: the responder commits the write on this edge.
    - Go to RESP.
  - If the strobe condition is false: increment the counter. When counter==TIMEOUT, set exc_timeout and go to RESP with no strobe.
  - Strobes are high for exactly one cycle per access.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - resp_data and exc_* are held until the next accept, then cleared.
  - A req_valid seen during ISSUE or RESP is not accepted.
- Latency, accept edge to resp_valid, with ready and !busy: 2 cycles (IDLE→ISSUE→RESP). Each wait cycle adds 1.
- Pre-check failures respond in 1 cycle.
- Back-to-back requests: the minimum spacing between accepts is 3 cycles.
- Exceptions are mutually exclusive per response.

Test Plan:
- Reset with rst=0 for 2 cycles and req_valid=1 -> req_ready low during reset; all outputs 0; no strobe.
- SW addr 0x10, data 0xDEADBEEF, bus_ready=1, busy=0 -> bus_wd pulse exactly 1 cycle with size 10 and bus_data_in 0xDEADBEEF; resp_valid 2 cycles after accept; no exceptions.
- LB addr 0x10 with responder returning 0x00000080 -> resp_rdata 0xFFFFFF80. Same access as LBU -> 0x00000080. LH with 0x0000_8001 -> 0xFFFF8001.
- LW addr 0x12 -> exc_misaligned, resp_valid 1 cycle after accept, bus_rd never high. SH addr 0x11 -> same. LB addr 0x2000 -> exc_access.
- bus_busy held 1 for 3 cycles during an LW -> bus_rd asserted on the 4th ISSUE cycle, resp_valid 5 cycles after accept. busy held for 20 cycles -> exc_timeout after 16 ISSUE cycles, no strobe.
- rst=0 asserted during ISSUE -> IDLE next cycle, no resp_valid; the next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for the core data bus. It checks alignment and range,
// runs the ready/!busy handshake and returns one response pulse per access.
module load_store_unit #(
  parameter logic [31:0] RAM_START = 32'h0000_0000,
  parameter logic [31:0] RAM_END   = 32'h0000_0FFF,
  parameter int          TIMEOUT   = 15,
  parameter int          CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_misaligned,
  output logic        exc_access,
  output logic        exc_timeout,
  output logic        bus_rd,
  output logic        bus_wd,
  output logic [1:0]  bus_size_in,
  output logic [1:0]  bus_size_out,
  output logic [31:0] bus_addr_in,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_data_in,
  input  logic [31:0] bus_data_out,
  input  logic        bus_ready,
  input  logic        bus_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       size;
  logic             pre_illegal, pre_misal, pre_in_range, pre_fail;
  logic             strobe_ok;
  logic [31:0]      wdata_masked;
  logic [31:0]      rdata_ext;

  assign size         = req_funct3[1:0];
  assign pre_illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                        (req_we && req_funct3[2]);
  assign pre_misal    = ((size == 2'b01) && req_addr[0]) ||
                        ((size == 2'b10) && (req_addr[1:0] != 2'b00));
  // Offset form keeps the range check free of constant compares when RAM_START is 0.
  assign pre_in_range = (req_addr - RAM_START) <= (RAM_END - RAM_START);
  assign pre_fail     = pre_illegal || pre_misal || !pre_in_range;

  // Reset dominates so nothing can look accepted while rst is held low.
  assign req_ready = rst && (state == IDLE);
  assign strobe_ok = (state == ISSUE) && bus_ready && !bus_busy;
  assign bus_rd    = strobe_ok && !we_q;
  assign bus_wd    = strobe_ok && we_q;

  always_comb begin
    case (size)
      2'b00:   wdata_masked = {24'b0, req_wdata[7:0]};
      2'b01:   wdata_masked = {16'b0, req_wdata[15:0]};
      default: wdata_masked = req_wdata;
    endcase
  end

  always_comb begin
    case (f3_q)
      3'b000:  rdata_ext = {{24{bus_data_out[7]}}, bus_data_out[7:0]};
      3'b100:  rdata_ext = {24'b0, bus_data_out[7:0]};
      3'b001:  rdata_ext = {{16{bus_data_out[15]}}, bus_data_out[15:0]};
      3'b101:  rdata_ext = {16'b0, bus_data_out[15:0]};
      default: rdata_ext = bus_data_out;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = pre_fail ? RESP : ISSUE;
      ISSUE:   if (strobe_ok || (cnt == CNT_MAX)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      we_q           <= 1'b0;
      f3_q           <= 3'b000;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      exc_misaligned <= 1'b0;
      exc_access     <= 1'b0;
      exc_timeout    <= 1'b0;
      bus_size_in    <= 2'b00;
      bus_size_out   <= 2'b00;
      bus_addr_in    <= '0;
      bus_addr_out   <= '0;
      bus_data_in    <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= (state_nxt == RESP);
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q           <= req_we;
            f3_q           <= req_funct3;
            cnt            <= '0;
            bus_size_in    <= size;
            bus_size_out   <= size;
            bus_addr_in    <= req_addr;
            bus_addr_out   <= req_addr;
            bus_data_in    <= wdata_masked;
            resp_rdata     <= '0;
            exc_timeout    <= 1'b0;
            exc_access     <= pre_illegal || (!pre_misal && !pre_in_range);
            exc_misaligned <= !pre_illegal && pre_misal;
          end
        end
        ISSUE: begin
          if (strobe_ok) begin
            if (!we_q) resp_rdata <= rdata_ext;
          end else if (cnt == CNT_MAX) begin
            exc_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a transaction-level model predicts strobe and
// response cycles, data and exceptions; one process compares every cycle.
module tb_load_store_unit;

  localparam logic [31:0] RAM_END_C = 32'h0000_0FFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        exc_misaligned, exc_access, exc_timeout;
  logic        bus_rd, bus_wd;
  logic [1:0]  bus_size_in, bus_size_out;
  logic [31:0] bus_addr_in, bus_addr_out, bus_data_in;
  logic [31:0] bus_data_out;
  logic        bus_ready, bus_busy;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_misaligned(exc_misaligned), .exc_access(exc_access), .exc_timeout(exc_timeout),
    .bus_rd(bus_rd), .bus_wd(bus_wd),
    .bus_size_in(bus_size_in), .bus_size_out(bus_size_out),
    .bus_addr_in(bus_addr_in), .bus_addr_out(bus_addr_out),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_ready(bus_ready), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;
  logic chk_en = 1'b0;

  // Model of the outstanding access (cycle numbers are values of cyc).
  int          m_acc = -10, m_strobe = -1, m_resp = -10;
  logic        m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_exc;   // {access, misaligned, timeout}

  int          last_lat = -1;
  logic [31:0] last_rdata;
  logic [2:0]  last_exc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] b, h;
    b = d % 256;
    h = d % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(rst && !(cyc > m_acc && cyc <= m_resp)));
      check("bus_rd", 32'(bus_rd), 32'(cyc == m_strobe && !m_we));
      check("bus_wd", 32'(bus_wd), 32'(cyc == m_strobe && m_we));
      check("resp_valid", 32'(resp_valid), 32'(cyc == m_resp));
      if (cyc == m_strobe) begin
        check("bus_addr_in", bus_addr_in, m_addr);
        check("bus_addr_out", bus_addr_out, m_addr);
        check("bus_size_in", 32'(bus_size_in), 32'(m_size));
        check("bus_size_out", 32'(bus_size_out), 32'(m_size));
        check("bus_data_in", bus_data_in, m_wdata);
      end
      if (cyc == m_resp) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("exc", 32'({exc_access, exc_misaligned, exc_timeout}), 32'(m_exc));
      end
      if (resp_valid) begin
        last_lat   = cyc - m_acc;
        last_rdata = resp_rdata;
        last_exc   = {exc_access, exc_misaligned, exc_timeout};
      end
    end
  end

  task automatic rand_bus();
    bus_ready = 1'($urandom_range(0, 1));
    bus_busy  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] bdata,
                        input int w, input int gap, input int rst_at);
    logic ill, mis, oor, done;
    logic [1:0] sz;
    int c, idx;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #2;
      req_valid = 1'b0;
      rand_bus();
    end
    @(posedge clk); #2;
    c = cyc;
    last_lat = -1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    bus_data_out = bdata;
    rand_bus();
    sz  = f3[1:0];
    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    mis = !ill && (((sz == 2'd1) && (addr % 2 != 0)) || ((sz == 2'd2) && (addr % 4 != 0)));
    oor = !ill && !mis && (addr > RAM_END_C);
    m_we = we; m_addr = addr; m_size = sz;
    m_wdata = (sz == 2'd0) ? wdata % 256 : (sz == 2'd1) ? wdata % 65536 : wdata;
    m_acc = c;
    if (ill || mis || oor) begin
      m_strobe = -1; m_resp = c + 1; m_exc = {ill || oor, mis, 1'b0}; m_rdata = 0;
    end else if (w < 16) begin
      m_strobe = c + 1 + w; m_resp = c + 2 + w; m_exc = 3'b000;
      m_rdata = we ? 32'd0 : extend(f3, bdata);
    end else begin
      m_strobe = -1; m_resp = c + 17; m_exc = 3'b001; m_rdata = 0;
    end
    done = 1'b0;
    while (!done && cyc < m_resp) begin
      @(posedge clk); #2;
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      idx = cyc - c - 1;
      if (idx < w) begin
        case ($urandom_range(0, 2))
          0:       begin bus_ready = 1'b0; bus_busy = 1'b0; end
          1:       begin bus_ready = 1'b0; bus_busy = 1'b1; end
          default: begin bus_ready = 1'b1; bus_busy = 1'b1; end
        endcase
      end else begin
        bus_ready = 1'b1; bus_busy = 1'b0;
      end
      if (rst_at > 0 && cyc == c + rst_at) begin
        rst = 1'b0; bus_ready = 1'b0; bus_busy = 1'b1;
        m_acc = -10; m_strobe = -1; m_resp = -10;
        @(posedge clk); #2;
        rst = 1'b1; req_valid = 1'b0;
        done = 1'b1;
      end
    end
  endtask

  task automatic pin(input string name, input int lat, input logic [31:0] rdata,
                     input logic [2:0] exc);
    @(negedge clk); #1;
    check({name, "_lat"}, 32'(last_lat), 32'(lat));
    check({name, "_rdata"}, last_rdata, rdata);
    check({name, "_exc"}, 32'(last_exc), 32'(exc));
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          w;
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; bus_data_out = 32'h0;
    bus_ready = 1'b1; bus_busy = 1'b0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(negedge clk); #1;
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_exc", 32'({exc_access, exc_misaligned, exc_timeout}), 32'h0);
    check("rst_bus_addr", bus_addr_out, 32'h0);
    check("rst_bus_data", bus_data_in, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1; req_valid = 1'b0;

    do_txn(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    pin("sw", 2, 32'h0, 3'b000);
    do_txn(1'b0, 3'd0, 32'h10, 32'h0, 32'h0000_0080, 0, 0, 0);
    pin("lb", 2, 32'hFFFF_FF80, 3'b000);
    do_txn(1'b0, 3'd4, 32'h10, 32'h0, 32'h0000_0080, 0, 0, 0);
    pin("lbu", 2, 32'h0000_0080, 3'b000);
    do_txn(1'b0, 3'd1, 32'h10, 32'h0, 32'h0000_8001, 0, 1, 0);
    pin("lh", 2, 32'hFFFF_8001, 3'b000);
    do_txn(1'b0, 3'd5, 32'h12, 32'h0, 32'hAAAA_8001, 0, 0, 0);
    pin("lhu", 2, 32'h0000_8001, 3'b000);
    do_txn(1'b0, 3'd2, 32'h12, 32'h0, 32'h1, 0, 0, 0);
    pin("lw_mis", 1, 32'h0, 3'b010);
    do_txn(1'b1, 3'd1, 32'h11, 32'h1234, 32'h1, 0, 0, 0);
    pin("sh_mis", 1, 32'h0, 3'b010);
    do_txn(1'b0, 3'd0, 32'h2000, 32'h0, 32'h1, 0, 0, 0);
    pin("lb_oor", 1, 32'h0, 3'b100);
    do_txn(1'b1, 3'd4, 32'h10, 32'h0, 32'h1, 0, 0, 0);
    pin("sbu_ill", 1, 32'h0, 3'b100);
    do_txn(1'b0, 3'd2, 32'hFFC, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
    pin("lw_top", 2, 32'hCAFE_F00D, 3'b000);
    do_txn(1'b0, 3'd2, 32'h20, 32'h0, 32'h1234_5678, 3, 0, 0);
    pin("lw_busy3", 5, 32'h1234_5678, 3'b000);
    do_txn(1'b0, 3'd2, 32'h20, 32'h0, 32'h1234_5678, 15, 0, 0);
    pin("lw_busy15", 17, 32'h1234_5678, 3'b000);
    do_txn(1'b0, 3'd2, 32'h20, 32'h0, 32'h1234_5678, 20, 0, 0);
    pin("lw_timeout", 17, 32'h0, 3'b001);

    do_txn(1'b0, 3'd2, 32'h20, 32'h0, 32'h5555_AAAA, 10, 0, 3);
    @(negedge clk); #1;
    check("midrst_rdata", resp_rdata, 32'h0);
    check("midrst_exc", 32'({exc_access, exc_misaligned, exc_timeout}), 32'h0);
    check("midrst_addr", bus_addr_out, 32'h0);
    do_txn(1'b0, 3'd2, 32'h24, 32'h0, 32'h0BAD_CAFE, 0, 0, 0);
    pin("after_rst", 2, 32'h0BAD_CAFE, 3'b000);

    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       f3 = 3'($urandom_range(0, 7));
        1, 2:    f3 = 3'd4 + 3'($urandom_range(0, 1));
        default: f3 = 3'($urandom_range(0, 2));
      endcase
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'h0FF0 + 32'($urandom_range(0, 31));
        default: addr = 32'($urandom_range(0, 32'h0FFF));
      endcase
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << f3[1:0]) - 1);
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      do_txn(we, f3, addr, $urandom, $urandom, w, int'($urandom_range(0, 2)), 0);
    end

    @(posedge clk); #2;
    req_valid = 1'b0;
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
